// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundles the pipeline sequencer's request/handshake inputs and its
// enable/flush/status outputs. CLK and RESET_N are kept as plain ports.
//   master : side that drives the requests (debug unit, hazard unit, dmem)
//   slave  : the sequencer itself
// Parameter CNT_W sets the width of the advance-cycle counter.
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             I_RUN;
  logic             I_STEP;
  logic             I_LOAD_USE;
  logic             I_BRANCH_TAKEN;
  logic             I_HALT_INSTR;
  logic             I_MEM_REQ;
  logic             I_MEM_READY;
  logic             O_PC_EN;
  logic             O_IF_ID_EN;
  logic             O_ID_EX_EN;
  logic             O_EX_MEM_EN;
  logic             O_MEM_WB_EN;
  logic             O_IF_ID_FLUSH;
  logic             O_ID_EX_FLUSH;
  logic [2:0]       O_STATE;
  logic [CNT_W-1:0] O_CYCLE_COUNT;
  logic             O_HALTED;
  logic             O_ERROR;

  modport master (
    output I_RUN, I_STEP, I_LOAD_USE, I_BRANCH_TAKEN, I_HALT_INSTR,
           I_MEM_REQ, I_MEM_READY,
    input  O_PC_EN, O_IF_ID_EN, O_ID_EX_EN, O_EX_MEM_EN, O_MEM_WB_EN,
           O_IF_ID_FLUSH, O_ID_EX_FLUSH, O_STATE, O_CYCLE_COUNT,
           O_HALTED, O_ERROR
  );

  modport slave (
    input  I_RUN, I_STEP, I_LOAD_USE, I_BRANCH_TAKEN, I_HALT_INSTR,
           I_MEM_REQ, I_MEM_READY,
    output O_PC_EN, O_IF_ID_EN, O_ID_EX_EN, O_EX_MEM_EN, O_MEM_WB_EN,
           O_IF_ID_FLUSH, O_ID_EX_FLUSH, O_STATE, O_CYCLE_COUNT,
           O_HALTED, O_ERROR
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central sequencer of the five-stage MIPS pipeline. Produces the stage
// register enables and bubble flushes from run/step requests, hazards,
// branch resolution and the data-memory handshake; drains the pipe on HALT
// and counts cycles in which EX/MEM advances.
// Ports:
//   CLK      : clock, rising edge
//   RESET_N  : synchronous active-low reset
//   ctrl     : pipeline_ctrl_if.slave (requests in, enables/flushes/status out)
// Optional build macro MEM_TIMEOUT_EN: adds a MEM_WAIT watchdog that moves to
// HALTED and raises a sticky O_ERROR after MEM_TIMEOUT unanswered wait cycles.
// Without it O_ERROR is tied low and MEM_WAIT may last forever.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic           CLK,
  input  logic           RESET_N,
  pipeline_ctrl_if.slave ctrl
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_STEP     = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_DRAIN    = 3'd4,
    S_HALTED   = 3'd5
  } state_e;

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || MEM_TIMEOUT < 1) begin : g_cfg_check
    $error("pipeline_ctrl: DRAIN_CYCLES or MEM_TIMEOUT out of range");
  end

  state_e           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic             step_pend_q, step_pend_d;
  logic [CNT_W-1:0] cnt_q;

  logic mem_stall;
  logic timeout_hit;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl;

  // Advance-cycle modifiers (b)..(d); the mem stall (a) is handled per state.
  logic adv_pc, adv_ifid, adv_ifid_fl, adv_idex_fl, adv_halt;

  assign mem_stall = ctrl.I_MEM_REQ && !ctrl.I_MEM_READY;

  always_comb begin
    adv_pc      = 1'b1;
    adv_ifid    = 1'b1;
    adv_ifid_fl = 1'b0;
    adv_idex_fl = 1'b0;
    adv_halt    = 1'b0;
    if (ctrl.I_BRANCH_TAKEN) begin
      adv_ifid_fl = 1'b1;
      adv_idex_fl = 1'b1;
    end else if (ctrl.I_LOAD_USE) begin
      adv_pc      = 1'b0;
      adv_ifid    = 1'b0;
      adv_idex_fl = 1'b1;
    end else if (ctrl.I_HALT_INSTR) begin
      adv_pc      = 1'b0;
      adv_ifid    = 1'b0;
      adv_halt    = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    step_pend_d = step_pend_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_fl     = 1'b0;
    idex_fl     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ctrl.I_RUN)       state_d = S_RUN;
        else if (ctrl.I_STEP) state_d = S_STEP;
      end

      // RUN, STEP and the ready cycle of MEM_WAIT share the advance logic;
      // only the successor state differs.
      S_RUN, S_STEP, S_MEM_WAIT: begin
        if (state_q == S_RUN && !ctrl.I_RUN) begin
          state_d = S_IDLE;
        end else if (state_q != S_MEM_WAIT && mem_stall) begin
          state_d = S_MEM_WAIT;
          if (state_q == S_STEP) step_pend_d = 1'b1;
        end else if (state_q == S_MEM_WAIT && !ctrl.I_MEM_READY) begin
          if (timeout_hit) state_d = S_HALTED;
        end else begin
          pc_en    = adv_pc;
          ifid_en  = adv_ifid;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          ifid_fl  = adv_ifid_fl;
          idex_fl  = adv_idex_fl;
          if (adv_halt) begin
            drain_d = 4'(DRAIN_CYCLES);
            state_d = S_DRAIN;
          end else if (state_q == S_STEP) begin
            state_d = S_IDLE;
          end else if (state_q == S_MEM_WAIT) begin
            state_d = step_pend_q ? S_IDLE : S_RUN;
          end
          if (state_q == S_MEM_WAIT) step_pend_d = 1'b0;
        end
      end

      // Older instructions keep moving while IF/ID is held and ID/EX gets
      // bubbles, so nothing behind the HALT can reach EX.
      S_DRAIN: begin
        if (!mem_stall) begin
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          idex_fl  = 1'b1;
          drain_d  = drain_q - 4'd1;
          if (drain_q <= 4'd1) state_d = S_HALTED;
        end
      end

      S_HALTED: ;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      drain_q     <= 4'd0;
      step_pend_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      step_pend_q <= step_pend_d;
      // Saturating count of cycles in which EX/MEM advances.
      if (exmem_en && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) < 8) ? 8 : $clog2(MEM_TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_q;
  logic              err_q;

  // Hit on the MEM_TIMEOUT-th consecutive unanswered MEM_WAIT cycle.
  assign timeout_hit = (state_q == S_MEM_WAIT) && !ctrl.I_MEM_READY &&
                       (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == S_MEM_WAIT && !ctrl.I_MEM_READY) wait_q <= wait_q + WAIT_W'(1);
      else                                            wait_q <= '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign ctrl.O_ERROR = err_q;
`else
  assign timeout_hit  = 1'b0;
  assign ctrl.O_ERROR = 1'b0;
`endif

  // Enables and flushes are forced low while reset is asserted.
  assign ctrl.O_PC_EN         = RESET_N & pc_en;
  assign ctrl.O_IF_ID_EN      = RESET_N & ifid_en;
  assign ctrl.O_ID_EX_EN      = RESET_N & idex_en;
  assign ctrl.O_EX_MEM_EN     = RESET_N & exmem_en;
  assign ctrl.O_MEM_WB_EN     = RESET_N & memwb_en;
  assign ctrl.O_IF_ID_FLUSH   = RESET_N & ifid_fl;
  assign ctrl.O_ID_EX_FLUSH   = RESET_N & idex_fl;
  assign ctrl.O_STATE         = state_q;
  assign ctrl.O_CYCLE_COUNT   = cnt_q;
  assign ctrl.O_HALTED        = (state_q == S_HALTED);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed, table-driven bench for pipeline_ctrl (DRAIN_CYCLES=3, CNT_W=4 so
// that counter saturation is reachable). Each table row is one clock cycle:
// inputs applied just after a rising edge, outputs compared mid-cycle.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int CW = 4;

  typedef struct {
    logic          rst_n, run, step, lu, br, halt, mreq, mrdy;
    logic [4:0]    en;    // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [1:0]    fl;    // {if_id_flush, id_ex_flush}
    logic [2:0]    st;
    logic [CW-1:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  vec_t vq[$];

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(
    .DRAIN_CYCLES(3),
    .CNT_W       (CW),
    .MEM_TIMEOUT (255)
  ) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .ctrl   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, run, step, lu, br, halt, mreq, mrdy,
                              input logic [4:0] en, input logic [1:0] fl,
                              input logic [2:0] st, input logic [CW-1:0] cnt);
    vec_t v;
    v.rst_n = r;  v.run = run;   v.step = step; v.lu = lu;
    v.br    = br; v.halt = halt; v.mreq = mreq; v.mrdy = mrdy;
    v.en = en; v.fl = fl; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_n              = v.rst_n;
    bus.I_RUN          = v.run;
    bus.I_STEP         = v.step;
    bus.I_LOAD_USE     = v.lu;
    bus.I_BRANCH_TAKEN = v.br;
    bus.I_HALT_INSTR   = v.halt;
    bus.I_MEM_REQ      = v.mreq;
    bus.I_MEM_READY    = v.mrdy;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [4:0] en_act;
    logic [1:0] fl_act;
    vec_t       v;

    //      rst run stp lu br hlt mrq mrd  en        fl     st    cnt
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 3'd0, 4'd0));  // 0 reset, run held high
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 3'd0, 4'd0));  // 1 IDLE -> RUN
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 3'd1, 4'd0));  // 2 free run
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 3'd1, 4'd1));  // 3
    vq.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 5'b00111, 2'b01, 3'd1, 4'd2));  // 4 load-use
    vq.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 5'b11111, 2'b11, 3'd1, 4'd3));  // 5 branch beats load-use
    vq.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 5'b11111, 2'b11, 3'd1, 4'd4));  // 6 branch beats halt
    vq.push_back(mk(1, 1, 0, 1, 0, 1, 0, 0, 5'b00111, 2'b01, 3'd1, 4'd5));  // 7 load-use beats halt
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 5'b00000, 2'b00, 3'd1, 4'd6));  // 8 mem stall in RUN
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 5'b00000, 2'b00, 3'd3, 4'd6));  // 9 MEM_WAIT
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 5'b00000, 2'b00, 3'd3, 4'd6));  // 10
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 5'b00000, 2'b00, 3'd3, 4'd6));  // 11
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 5'b11111, 2'b00, 3'd3, 4'd6));  // 12 ready -> RUN
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 3'd1, 4'd7));  // 13
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 3'd1, 4'd8));  // 14 run dropped
    vq.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 3'd0, 4'd8));  // 15 step pulse
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 3'd2, 4'd8));  // 16 single advance
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 3'd0, 4'd9));  // 17 back in IDLE
    vq.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 3'd0, 4'd9));  // 18 step again
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 2'b00, 3'd2, 4'd9));  // 19 step stalled
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 5'b00000, 2'b00, 3'd3, 4'd9));  // 20 run ignored in wait
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 5'b11111, 2'b00, 3'd3, 4'd9));  // 21 ready -> IDLE
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 3'd0, 4'd10)); // 22
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 3'd0, 4'd10)); // 23 run wins over step
    vq.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 5'b00111, 2'b00, 3'd1, 4'd10)); // 24 HALT decoded
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b00111, 2'b01, 3'd4, 4'd11)); // 25 drain 3->2
    vq.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 5'b00111, 2'b01, 3'd4, 4'd12)); // 26 drain 2->1, branch/step ignored
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 5'b00000, 2'b00, 3'd4, 4'd13)); // 27 stall freezes drain
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b00111, 2'b01, 3'd4, 4'd13)); // 28 drain 1->0
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 3'd5, 4'd14)); // 29 HALTED
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 3'd5, 4'd14)); // 30
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 3'd5, 4'd14)); // 31 reset from HALTED
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00, 3'd0, 4'd0));  // 32

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 2'b0, 3'd0, 4'd0));
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      drive(v);
      #2;
      en_act = {bus.O_PC_EN, bus.O_IF_ID_EN, bus.O_ID_EX_EN, bus.O_EX_MEM_EN, bus.O_MEM_WB_EN};
      fl_act = {bus.O_IF_ID_FLUSH, bus.O_ID_EX_FLUSH};
      chk("enables", i, 32'(en_act), 32'(v.en));
      chk("flushes", i, 32'(fl_act), 32'(v.fl));
      chk("state",   i, 32'(bus.O_STATE), 32'(v.st));
      chk("count",   i, 32'(bus.O_CYCLE_COUNT), 32'(v.cnt));
      chk("halted",  i, 32'(bus.O_HALTED), 32'(v.st == 3'd5));
      chk("error",   i, 32'(bus.O_ERROR), 32'd0);
      @(posedge clk);
      #1;
    end

    // Counter saturation: 20 free-run cycles must stop the 4-bit count at 15.
    drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b0, 2'b0, 3'd0, 4'd0));
    for (int c = 0; c < 21; c++) begin
      @(posedge clk);
      #1;
    end
    #1;
    chk("sat_state", 100, 32'(bus.O_STATE), 32'd1);
    chk("sat_ex_mem_en", 100, 32'(bus.O_EX_MEM_EN), 32'd1);
    chk("sat_count", 100, 32'(bus.O_CYCLE_COUNT), 32'd15);
    @(posedge clk);
    #2;
    chk("sat_hold", 101, 32'(bus.O_CYCLE_COUNT), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
